// File: rtl/sseg_disp_mux_n.sv
// Time-multiplexed N-digit common-anode seven-segment driver with hex decode,
// per-frame input shadowing, anti-ghosting blank gap and leading-zero suppression.
module sseg_disp_mux_n #(
    parameter int N_DIGITS  = 4,
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] hex_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic                  lz_en,
    output logic [N_DIGITS-1:0]   an,
    output logic [7:0]            sseg,
    output logic                  frame_tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_L  = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] hex_q, hex_d;
    logic [N_DIGITS-1:0]   dp_q, dp_d;
    logic [N_DIGITS-1:0]   blank_q, blank_d;
    logic                  lz_q, lz_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [7:0]            sseg_q, sseg_d;
    logic                  tick_q, tick_d;

    logic       load;
    logic [3:0] nib;
    logic       dp_cur, blank_cur, supp_cur, zero_above, dark;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        load  = (cnt_q == '0) && (idx_q == '0);
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        hex_d   = hex_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        lz_d    = lz_q;
        if (load) begin
            hex_d   = hex_in;
            dp_d    = dp_in;
            blank_d = blank_in;
            lz_d    = lz_en;
        end
        tick_d = load;
    end

    // Walk from the most significant digit down so zero_above holds "this and all higher nibbles are 0".
    always_comb begin
        nib        = 4'h0;
        dp_cur     = 1'b0;
        blank_cur  = 1'b0;
        supp_cur   = 1'b0;
        zero_above = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (hex_q[4*i +: 4] == 4'h0);
            if (idx_q == IDX_W'(i)) begin
                nib       = hex_q[4*i +: 4];
                dp_cur    = dp_q[i];
                blank_cur = blank_q[i];
                supp_cur  = lz_q && (i != 0) && zero_above;
            end
        end

        dark   = (cnt_q < BLANK_L) || blank_cur || supp_cur;
        an_d   = '1;
        sseg_d = 8'hFF;
        if (!dark) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                an_d[i] = (idx_q != IDX_W'(i));
            end
            sseg_d = {~dp_cur, hex7(nib)};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            hex_q   <= '0;
            dp_q    <= '0;
            blank_q <= '1;
            lz_q    <= 1'b0;
            an_q    <= '1;
            sseg_q  <= 8'hFF;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            hex_q   <= hex_d;
            dp_q    <= dp_d;
            blank_q <= blank_d;
            lz_q    <= lz_d;
            an_q    <= an_d;
            sseg_q  <= sseg_d;
            tick_q  <= tick_d;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_tick = tick_q;

endmodule

// File: doc/sseg_disp_mux_n.md
# sseg_disp_mux_n

Parametrised, time-multiplexed N-digit seven-segment display driver with built-in hex decoding. Takes packed hex nibbles plus per-digit decimal-point and blank masks, samples them once per refresh frame into a shadow register, and scans the digits with an anti-ghosting blanking gap, optional leading-zero suppression, and a frame tick. Sits between the switch/counter datapath and the board's common-anode display pins. It supersedes the fixed four-instance decoder arrangement with its external multiplexer.

## Interface
- N_DIGITS, 4, number of digits scanned; legal range 1..8.
- DIV, 50000, clock cycles per digit slot; must be ≥ BLANK_CYC+1.
- BLANK_CYC, 500, cycles at the start of each slot with all anodes off.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- hex_in  in  4*N_DIGITS  digit nibbles; digit i = hex_in[4i+3:4i]; digit 0 is rightmost/LSD.
- dp_in  in  N_DIGITS  1 = light the decimal point of digit i.
- blank_in  in  N_DIGITS  1 = force digit i dark (anode off).
- lz_en  in  1  1 = suppress leading zeros.
- an  out  N_DIGITS  anode enables, active-low.
- sseg  out  8  {dp,g,f,e,d,c,b,a}, active-low.
- frame_tick  out  1  one-cycle pulse per frame.

## Operation
- Slot counter cnt runs 0..DIV-1. Digit index idx runs 0..N_DIGITS-1 and advances when cnt wraps. idx wraps from N_DIGITS-1 to 0.
- Shadow load occurs in every cycle with cnt==0 and idx==0, including the first cycle after reset release. The load captures hex_in, dp_in, blank_in and lz_en. Inputs are ignored between loads, so no tearing occurs within a frame.
- Leading-zero suppression, evaluated on the shadow:
  - Applies only when shadow lz_en=1.
  - Digit i is suppressed if i≠0 and every shadow nibble at position j≥i equals 0.
  - Digit 0 is never suppressed.
  - dp of a suppressed digit is also dark.
- Current digit idx is dark when cnt<BLANK_CYC, or shadow blank[idx]=1, or the digit is suppressed.
- Dark digit: an=all ones, sseg=8'hFF.
- Lit digit:
  - an has only bit idx low.
  - sseg[6:0] = active-low hex pattern of the nibble: 0→7'b1000000, 1→7'b1111001, 2→7'b0100100, 3→7'b0110000, 4→7'b0011001, 5→7'b0010010, 6→7'b0000010, 7→7'b1111000, 8→7'b0000000, 9→7'b0010000, A→7'b0001000, b→7'b0000011, C→7'b1000110, d→7'b0100001, E→7'b0000110, F→7'b0001110.
  - sseg[7] = ~dp.

## Timing
- Reset (asynchronous assert, reset=0):
  - cnt=0, idx=0, shadow=0 (blank mask all ones).
  - an=all ones, sseg=8'hFF, frame_tick=0.
- Release is synchronous to clk. The first post-reset edge performs the shadow load.
- All outputs are registered. an, sseg and frame_tick reflect the (cnt, idx, shadow) state of the previous cycle, so latency is exactly 1 clock.
- frame_tick is high for one cycle, the cycle after each shadow load. Period = N_DIGITS*DIV cycles.
- Frame length = N_DIGITS*DIV cycles. Each digit is lit for DIV-BLANK_CYC cycles per frame.
- N_DIGITS=1: idx stays 0; a load occurs every DIV cycles.
- Reset asserted mid-frame: outputs go dark immediately, without waiting for a clock. Scanning restarts at idx 0 with a fresh load.
- An input change in the same cycle as a load is captured. An input change one cycle after a load appears only in the next frame.

## Test plan
Unless stated, N_DIGITS=4, DIV=8, BLANK_CYC=2.
- Reset held, then released with hex_in=16'h2C2D -> an=4'hF and sseg=8'hFF while held. frame_tick=1 on the 2nd post-release edge. an=4'b1110 with sseg=8'hA1 ('d') from cycle 3 to cycle 8.
- Full scan of hex_in=16'h2C2D, dp_in=4'b1100 -> per 8-cycle slot: 2 dark cycles, then 6 lit cycles. Lit digits in order: d, 2, C, 2. dp low only on digits 2 and 3. Frame period = 32 cycles.
- lz_en=1, hex_in=16'h0030 -> digits 3 and 2 dark for their whole slots. Digits 1 and 0 show 3 and 0. hex_in=16'h0000 shows only digit 0 as '0'.
- blank_in=4'b0101 with hex_in=16'h1234 -> only digits 3 (1) and 1 (3) light.
- Change hex_in from 16'h1111 to 16'hFFFF mid-frame at idx=2 -> remainder of the frame still shows 1. The next frame shows F (sseg=8'h8E).
- Assert reset at idx=3 with cnt=4 -> an=4'hF asynchronously. After release, scanning restarts at digit 0 with frame_tick one cycle after the first edge.
